// File: rtl/otter_cu_fsm.sv
// ---------------------------------------------------------------------------
// otter_cu_fsm
//   Multicycle control-unit state machine for the OTTER RV32I core.
//   Sequences INIT -> FETCH -> EXEC [-> WB] [-> TRAP] -> FETCH and produces
//   the datapath strobes. It decides only *when* the PC register updates;
//   the next-PC source is chosen elsewhere.
//
// Parameters
//   ENABLE_INTR : 0 ignores CU_intr completely, so TRAP is never entered.
//   INIT_CYCLES : number of cycles spent in INIT after reset (>= 1).
//
// Ports
//   CU_clk        in   clock, all state changes on the rising edge
//   CU_rst        in   synchronous active-high reset, beats every other event
//   CU_opcode     in   instruction[6:0]
//   CU_func3      in   instruction[14:12]
//   CU_intr       in   external interrupt request (level)
//   CU_mie        in   machine interrupt enable from the CSR file
//   CU_PC_write   out  PC register write enable (one pulse per instr / trap)
//   CU_regWrite   out  register-file write enable
//   CU_memWE2     out  data-memory write enable
//   CU_memRDEN1   out  instruction-memory read enable
//   CU_memRDEN2   out  data-memory read enable
//   CU_rf_reset   out  register-file / datapath clear
//   CU_csr_WE     out  CSR write enable
//   CU_int_taken  out  trap entry strobe
//   CU_mret_exec  out  mret strobe
//   CU_state      out  current state code (debug):
//                      INIT=0 FETCH=1 EXEC=2 WB=3 TRAP=4, 5-7 illegal
//
// Outputs are decoded combinationally from the state register (plus
// opcode/func3 while in EXEC); every output not named for a state is 0.
// ---------------------------------------------------------------------------
module otter_cu_fsm #(
  parameter int ENABLE_INTR = 1,
  parameter int INIT_CYCLES = 1
) (
  input  logic       CU_clk,
  input  logic       CU_rst,
  input  logic [6:0] CU_opcode,
  input  logic [2:0] CU_func3,
  input  logic       CU_intr,
  input  logic       CU_mie,
  output logic       CU_PC_write,
  output logic       CU_regWrite,
  output logic       CU_memWE2,
  output logic       CU_memRDEN1,
  output logic       CU_memRDEN2,
  output logic       CU_rf_reset,
  output logic       CU_csr_WE,
  output logic       CU_int_taken,
  output logic       CU_mret_exec,
  output logic [2:0] CU_state
);

  typedef enum logic [2:0] {
    ST_INIT  = 3'd0,
    ST_FETCH = 3'd1,
    ST_EXEC  = 3'd2,
    ST_WB    = 3'd3,
    ST_TRAP  = 3'd4
  } state_t;

  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

  // Last value of the INIT counter before moving on to FETCH.
  localparam logic [31:0] INIT_LAST = 32'(INIT_CYCLES - 1);

  state_t      r_state;
  logic [31:0] r_init_cnt;
  logic        r_intr_latch;

  logic w_req;
  logic w_pending;
  logic w_is_load;

  // A qualified request is remembered in r_intr_latch so a pulse that drops
  // before the instruction boundary still gets serviced.
  assign w_req     = CU_intr & CU_mie & (ENABLE_INTR != 0);
  assign w_pending = r_intr_latch | w_req;
  assign w_is_load = (CU_opcode == OPC_LOAD);

  always_ff @(posedge CU_clk) begin
    if (CU_rst) begin
      r_state      <= ST_INIT;
      r_init_cnt   <= 32'd0;
      r_intr_latch <= 1'b0;
    end else begin
      // Requests seen during TRAP are dropped; the latch empties as TRAP exits.
      if (r_state == ST_TRAP) begin
        r_intr_latch <= 1'b0;
      end else begin
        r_intr_latch <= r_intr_latch | w_req;
      end

      case (r_state)
        ST_INIT: begin
          if (r_init_cnt == INIT_LAST) begin
            r_state    <= ST_FETCH;
            r_init_cnt <= 32'd0;
          end else begin
            r_init_cnt <= r_init_cnt + 32'd1;
          end
        end
        ST_FETCH: r_state <= ST_EXEC;
        ST_EXEC: begin
          // A load is not an instruction boundary yet; it finishes in WB.
          if (w_is_load) begin
            r_state <= ST_WB;
          end else if (w_pending) begin
            r_state <= ST_TRAP;
          end else begin
            r_state <= ST_FETCH;
          end
        end
        ST_WB:   r_state <= w_pending ? ST_TRAP : ST_FETCH;
        ST_TRAP: r_state <= ST_FETCH;
        default: begin
          // Illegal codes recover through a fresh INIT sequence.
          r_state    <= ST_INIT;
          r_init_cnt <= 32'd0;
        end
      endcase
    end
  end

  always_comb begin
    CU_PC_write  = 1'b0;
    CU_regWrite  = 1'b0;
    CU_memWE2    = 1'b0;
    CU_memRDEN1  = 1'b0;
    CU_memRDEN2  = 1'b0;
    CU_rf_reset  = 1'b0;
    CU_csr_WE    = 1'b0;
    CU_int_taken = 1'b0;
    CU_mret_exec = 1'b0;
    case (r_state)
      ST_INIT:  CU_rf_reset = 1'b1;
      ST_FETCH: CU_memRDEN1 = 1'b1;
      ST_EXEC: begin
        case (CU_opcode)
          OPC_LOAD:   CU_memRDEN2 = 1'b1;
          OPC_STORE: begin
            CU_memWE2   = 1'b1;
            CU_PC_write = 1'b1;
          end
          OPC_BRANCH: CU_PC_write = 1'b1;
          OPC_OP, OPC_OPIMM, OPC_LUI, OPC_AUIPC, OPC_JAL, OPC_JALR: begin
            CU_PC_write = 1'b1;
            CU_regWrite = 1'b1;
          end
          OPC_SYSTEM: begin
            CU_PC_write = 1'b1;
            if (CU_func3 == 3'b000) begin
              CU_mret_exec = 1'b1;
            end else if (CU_func3 == 3'b001 || CU_func3 == 3'b010 ||
                         CU_func3 == 3'b011) begin
              CU_regWrite = 1'b1;
              CU_csr_WE   = 1'b1;
            end
          end
          // Unknown opcodes retire as a NOP.
          default:    CU_PC_write = 1'b1;
        endcase
      end
      ST_WB: begin
        CU_regWrite = 1'b1;
        CU_PC_write = 1'b1;
      end
      ST_TRAP: begin
        CU_int_taken = 1'b1;
        CU_PC_write  = 1'b1;
      end
      default: ;
    endcase
  end

  assign CU_state = r_state;

endmodule

// File: tb/tb_otter_cu_fsm.sv
// ---------------------------------------------------------------------------
// tb_otter_cu_fsm
//   Two instances share the stimulus: dut (ENABLE_INTR=1, INIT_CYCLES=3) and
//   dut2 (ENABLE_INTR=0, INIT_CYCLES=1). Each has a reference model that
//   tracks instruction progress and recomputes the strobes from the opcode
//   table. Inputs change 2 time units after the falling edge; the model
//   advances on the rising edge; the compare process checks at falling+1.
// ---------------------------------------------------------------------------
module tb_otter_cu_fsm;

  // ---------------- clock / reset / inputs ----------------
  logic       clk = 1'b0;
  logic       rst;
  logic [6:0] opcode;
  logic [2:0] func3;
  logic       intr;
  logic       mie;

  always #5 clk = ~clk;

  logic       pc1, rw1, we1, rd1a, rd1b, rf1, csr1, it1, mr1;
  logic [2:0] st1;
  logic       pc2, rw2, we2, rd2a, rd2b, rf2, csr2, it2, mr2;
  logic [2:0] st2;

  otter_cu_fsm #(.ENABLE_INTR(1), .INIT_CYCLES(3)) dut (
    .CU_clk(clk), .CU_rst(rst), .CU_opcode(opcode), .CU_func3(func3),
    .CU_intr(intr), .CU_mie(mie),
    .CU_PC_write(pc1), .CU_regWrite(rw1), .CU_memWE2(we1),
    .CU_memRDEN1(rd1a), .CU_memRDEN2(rd1b), .CU_rf_reset(rf1),
    .CU_csr_WE(csr1), .CU_int_taken(it1), .CU_mret_exec(mr1),
    .CU_state(st1)
  );

  otter_cu_fsm #(.ENABLE_INTR(0), .INIT_CYCLES(1)) dut2 (
    .CU_clk(clk), .CU_rst(rst), .CU_opcode(opcode), .CU_func3(func3),
    .CU_intr(intr), .CU_mie(mie),
    .CU_PC_write(pc2), .CU_regWrite(rw2), .CU_memWE2(we2),
    .CU_memRDEN1(rd2a), .CU_memRDEN2(rd2b), .CU_rf_reset(rf2),
    .CU_csr_WE(csr2), .CU_int_taken(it2), .CU_mret_exec(mr2),
    .CU_state(st2)
  );

  localparam logic [6:0] LOAD   = 7'b0000011;
  localparam logic [6:0] STORE  = 7'b0100011;
  localparam logic [6:0] BRANCH = 7'b1100011;
  localparam logic [6:0] OP     = 7'b0110011;
  localparam logic [6:0] SYSTEM = 7'b1110011;

  logic [6:0] op_tab [12] = '{7'b0000011, 7'b0100011, 7'b1100011, 7'b0110011,
                              7'b0010011, 7'b0110111, 7'b0010111, 7'b1101111,
                              7'b1100111, 7'b1110011, 7'b1110011, 7'b0001111};

  // ---------------- scoreboard counters ----------------
  int n_checks = 0;
  int n_fail   = 0;
  int trap_cycles2 = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // st: phase of the current instruction (0 init, 1 fetch, 2 exec,
  // 3 load writeback, 4 trap); cnt: init cycles already spent;
  // latch: a request was seen and not yet serviced.
  typedef struct {
    int st;
    int cnt;
    bit latch;
    bit valid;
  } mstate_t;

  mstate_t m1 = '{0, 0, 1'b0, 1'b0};
  mstate_t m2 = '{0, 0, 1'b0, 1'b0};

  function automatic mstate_t mstep(input mstate_t m, input int ei, input int ic,
                                    input logic r, input logic irq, input logic en,
                                    input logic [6:0] op);
    mstate_t n = m;
    bit req  = irq && en && (ei != 0);
    bit pend = m.latch || req;
    if (r) begin
      n.st = 0; n.cnt = 0; n.latch = 1'b0; n.valid = 1'b1;
      return n;
    end
    if (!m.valid) return n;
    n.latch = (m.st == 4) ? 1'b0 : pend;
    if (m.st == 0) begin
      if (m.cnt + 1 >= ic) begin n.st = 1; n.cnt = 0; end
      else n.cnt = m.cnt + 1;
    end else if (m.st == 1) n.st = 2;
    else if (m.st == 2 && op == LOAD) n.st = 3;
    else if (m.st == 4) n.st = 1;
    else n.st = pend ? 4 : 1;
    return n;
  endfunction

  // Bit order: {pc, reg, we2, rden1, rden2, rf_reset, csr, int, mret}
  function automatic logic [8:0] exp_outs(input int st, input logic [6:0] op,
                                          input logic [2:0] f3);
    logic [8:0] v = 9'b0;
    if (st == 0) v[3] = 1'b1;
    else if (st == 1) v[5] = 1'b1;
    else if (st == 3) v[8:7] = 2'b11;
    else if (st == 4) begin v[8] = 1'b1; v[1] = 1'b1; end
    else if (st == 2) begin
      if (op == LOAD) v[4] = 1'b1;
      else begin
        v[8] = 1'b1;
        if (op == STORE) v[6] = 1'b1;
        else if (op inside {7'b0110011, 7'b0010011, 7'b0110111, 7'b0010111,
                            7'b1101111, 7'b1100111}) v[7] = 1'b1;
        else if (op == SYSTEM && f3 == 3'd0) v[0] = 1'b1;
        else if (op == SYSTEM && f3 >= 3'd1 && f3 <= 3'd3) begin
          v[7] = 1'b1; v[2] = 1'b1;
        end
      end
    end
    return v;
  endfunction

  always @(posedge clk) begin
    m1 = mstep(m1, 1, 3, rst, intr, mie, opcode);
    m2 = mstep(m2, 0, 1, rst, intr, mie, opcode);
  end

  // ---------------- compare process ----------------
  always @(negedge clk) begin
    #1;
    if (m1.valid) begin
      chk("dut_state", 32'(st1), 32'(m1.st));
      chk("dut_outs", 32'({pc1, rw1, we1, rd1a, rd1b, rf1, csr1, it1, mr1}),
          32'(exp_outs(m1.st, opcode, func3)));
    end
    if (m2.valid) begin
      chk("dut2_state", 32'(st2), 32'(m2.st));
      chk("dut2_outs", 32'({pc2, rw2, we2, rd2a, rd2b, rf2, csr2, it2, mr2}),
          32'(exp_outs(m2.st, opcode, func3)));
      if (st2 == 3'd4) trap_cycles2++;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic next_cycle();
    @(negedge clk);
    #2;
  endtask

  task automatic wait_state(input logic [2:0] s);
    for (int i = 0; i < 20; i++) begin
      if (st1 == s) return;
      next_cycle();
    end
    chk("wait_state_timeout", 32'(st1), 32'(s));
  endtask

  // ---------------- directed + random stimulus ----------------
  initial begin
    int pc_pulses;
    int traps;
    logic [2:0] seq [6];
    logic [2:0] seq_exp [6] = '{3'd0, 3'd0, 3'd0, 3'd1, 3'd2, 3'd1};

    rst = 1'b1; opcode = OP; func3 = 3'd0; intr = 1'b0; mie = 1'b0;

    // Reset, 3 INIT cycles, then one OP instruction.
    next_cycle();
    seq[0] = st1;
    chk("init_rf_reset", 32'(rf1), 32'd1);
    rst = 1'b0;
    for (int i = 1; i < 6; i++) begin
      next_cycle();
      seq[i] = st1;
      if (i < 3) chk("init_rf_reset_hold", 32'(rf1), 32'd1);
      if (i == 3) chk("fetch_rden1", 32'(rd1a), 32'd1);
      if (i == 4) chk("op_exec_pc_reg", 32'({pc1, rw1}), 32'b11);
    end
    for (int i = 0; i < 6; i++) chk("reset_state_seq", 32'(seq[i]), 32'(seq_exp[i]));

    // LOAD: EXEC reads data memory without touching the PC; WB retires.
    wait_state(3'd1);
    opcode = LOAD;
    pc_pulses = 0;
    next_cycle();
    chk("load_exec", 32'({rd1b, pc1}), 32'b10);
    pc_pulses += int'(pc1);
    next_cycle();
    chk("load_wb", 32'({rw1, pc1, st1}), 32'b11_011);
    pc_pulses += int'(pc1);
    next_cycle();
    pc_pulses += int'(pc1);
    chk("load_pc_pulses", 32'(pc_pulses), 32'd1);

    // STORE then BRANCH.
    wait_state(3'd1);
    opcode = STORE;
    next_cycle();
    chk("store_exec", 32'({we1, rw1, pc1}), 32'b101);
    next_cycle();
    chk("store_to_fetch", 32'(st1), 32'd1);
    opcode = BRANCH;
    next_cycle();
    chk("branch_exec", 32'({we1, rw1, pc1}), 32'b001);

    // One-cycle interrupt pulse during FETCH of an OP.
    wait_state(3'd1);
    opcode = OP; mie = 1'b1; intr = 1'b1;
    next_cycle();
    intr = 1'b0;
    chk("intr_exec_normal", 32'({st1, pc1, rw1, it1}), 32'b010_110);
    next_cycle();
    chk("intr_trap", 32'({st1, it1, pc1}), 32'b100_11);
    intr = 1'b1;                      // pulse during TRAP must be dropped
    next_cycle();
    intr = 1'b0;
    chk("trap_to_fetch", 32'(st1), 32'd1);
    next_cycle();
    chk("post_trap_exec", 32'(st1), 32'd2);
    next_cycle();
    chk("trap_pulse_ignored", 32'(st1), 32'd1);

    // mie=0 with intr held: dut never traps.
    mie = 1'b0; intr = 1'b1; traps = 0;
    for (int i = 0; i < 24; i++) begin
      opcode = op_tab[$urandom_range(0, 11)];
      func3  = 3'($urandom_range(0, 7));
      next_cycle();
      if (st1 == 3'd4) traps++;
    end
    chk("mie0_no_trap", 32'(traps), 32'd0);

    // ENABLE_INTR=0 with mie=1 and intr held: dut2 never traps.
    mie = 1'b1; traps = 0;
    for (int i = 0; i < 24; i++) begin
      opcode = op_tab[$urandom_range(0, 11)];
      next_cycle();
      if (st2 == 3'd4) traps++;
    end
    chk("disabled_no_trap", 32'(traps), 32'd0);
    intr = 1'b0;

    // Reset in the WB cycle of a load clears the pending request.
    next_cycle(); next_cycle();
    wait_state(3'd1);
    opcode = LOAD;
    next_cycle();
    intr = 1'b1;
    next_cycle();
    chk("rst_wb_state", 32'({st1, rw1}), 32'b011_1);
    intr = 1'b0; rst = 1'b1;
    next_cycle();
    rst = 1'b0;
    chk("rst_wb_to_init", 32'({st1, rw1, rf1}), 32'b000_01);
    traps = 0;
    for (int i = 0; i < 10; i++) begin
      next_cycle();
      if (st1 == 3'd4) traps++;
    end
    chk("rst_clears_latch", 32'(traps), 32'd0);

    // Randomized traffic.
    for (int i = 0; i < 600; i++) begin
      rst    = ($urandom_range(0, 63) == 0);
      opcode = ($urandom_range(0, 7) == 0) ? 7'($urandom) : op_tab[$urandom_range(0, 11)];
      func3  = 3'($urandom_range(0, 7));
      intr   = ($urandom_range(0, 7) == 0);
      mie    = ($urandom_range(0, 3) != 0);
      next_cycle();
    end
    rst = 1'b0;
    next_cycle();

    chk("dut2_never_trapped", 32'(trap_cycles2), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/otter_cu_fsm.md
Name: otter_cu_fsm

Overview:
- Multicycle control-unit state machine for the OTTER RV32I core.
- Sequences instruction fetch, execute, writeback and interrupt entry, and generates the `PC_write` enable for the program-counter register.
- Also generates register-file, memory and CSR strobes.
- Sits between the instruction-decode fields and the datapath. Next-PC source selection is done elsewhere; this block only decides when the PC updates.

Parameters:
- ENABLE_INTR, 1, when 0 the interrupt input is ignored and TRAP is never entered.
- INIT_CYCLES, 1, number of cycles spent in INIT after reset (must be >= 1).

Ports:
- CU_clk  input  1  system clock, all state updates on rising edge.
- CU_rst  input  1  synchronous, active-high reset.
- CU_opcode  input  7  instruction bits [6:0].
- CU_func3  input  3  instruction bits [14:12].
- CU_intr  input  1  external interrupt request, level.
- CU_mie  input  1  machine interrupt enable from the CSR file.
- CU_PC_write  output  1  PC register write enable.
- CU_regWrite  output  1  register-file write enable.
- CU_memWE2  output  1  data-memory write enable.
- CU_memRDEN1  output  1  instruction-memory read enable.
- CU_memRDEN2  output  1  data-memory read enable.
- CU_rf_reset  output  1  register-file / datapath clear.
- CU_csr_WE  output  1  CSR write enable.
- CU_int_taken  output  1  trap entry strobe (mepc/mcause capture, PC to mtvec).
- CU_mret_exec  output  1  mret strobe (PC to mepc).
- CU_state  output  3  current state encoding, for debug.

Behaviour:
- State encoding: INIT=0, FETCH=1, EXEC=2, WB=3, TRAP=4. Codes 5-7 are illegal and return to INIT on the next edge.
- Outputs are combinational from state (plus opcode/func3 in EXEC). Any output not listed for a state is 0.
- Reset: CU_rst=1 at an edge forces state=INIT, init counter=0 and intr_latch=0. This applies in any state, including mid-instruction. A reset edge always wins over every other event.
- INIT:
  - CU_rf_reset=1.
  - Stays INIT_CYCLES cycles, counted by the init counter, then goes to FETCH.
- FETCH: CU_memRDEN1=1; next state EXEC.
- EXEC, decoded by opcode:
  - LOAD 0000011: CU_memRDEN2=1, CU_PC_write=0; next state WB.
  - STORE 0100011: CU_memWE2=1, CU_PC_write=1.
  - BRANCH 1100011: CU_PC_write=1.
  - OP 0110011, OP-IMM 0010011, LUI 0110111, AUIPC 0010111, JAL 1101111, JALR 1100111: CU_PC_write=1, CU_regWrite=1.
  - SYSTEM 1110011 with func3=000 (mret): CU_PC_write=1, CU_mret_exec=1.
  - SYSTEM 1110011 with func3 001/010/011: CU_PC_write=1, CU_regWrite=1, CU_csr_WE=1.
  - Any other opcode or SYSTEM func3: CU_PC_write=1 only (executes as a NOP).
  - Next state for all non-LOAD instructions: TRAP if pending, else FETCH.
- WB: CU_regWrite=1, CU_PC_write=1; next state TRAP if pending, else FETCH.
- TRAP: CU_int_taken=1, CU_PC_write=1; next state FETCH.
- Interrupt pending:
  - intr_latch sets on any edge outside TRAP where CU_intr & CU_mie & ENABLE_INTR = 1.
  - intr_latch clears on the edge leaving TRAP. Requests present during TRAP are ignored.
  - pending = intr_latch | (CU_intr & CU_mie & ENABLE_INTR).
  - A request that arrives and drops before the instruction boundary is still serviced.
- An interrupt never preempts FETCH, or EXEC of a LOAD. It is taken only at an instruction boundary (EXEC→ or WB→).
- Simultaneous mret in EXEC and pending interrupt: mret strobe fires in EXEC, then TRAP follows.
- Latency:
  - Non-load instruction: 2 cycles.
  - Load: 3 cycles.
  - Trap entry: +1 cycle.
  - CU_PC_write pulses exactly once per instruction and once per trap.

Test Plan:
- Reset with INIT_CYCLES=3, opcode=0110011 → CU_rf_reset=1 for 3 cycles; then FETCH (memRDEN1=1); EXEC with PC_write=1 and regWrite=1; then FETCH. CU_state sequence 0,0,0,1,2,1.
- LOAD 0000011 → EXEC has memRDEN2=1, PC_write=0; WB has regWrite=1, PC_write=1. Exactly one PC_write pulse over 3 cycles.
- STORE 0100011 then BRANCH 1100011 → memWE2=1 only on the store's EXEC cycle; regWrite stays 0 for both instructions.
- CU_mie=1, 1-cycle CU_intr pulse during FETCH of an OP instruction → EXEC completes normally; next state TRAP with int_taken=1, PC_write=1; then FETCH. A second intr pulse during TRAP is not serviced.
- CU_mie=0 with CU_intr held at 1 → TRAP never entered. Repeat with ENABLE_INTR=0 and CU_mie=1 → same result.
- CU_rst asserted in the WB cycle of a load → next state INIT, regWrite=0, intr_latch cleared. Pending interrupt not taken afterwards.
